hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised hazard detection and forwarding unit for the pipelined MIPS core. It replaces the fixed EXE/MEM compare logic with a tracked pipeline of destination tags of configurable depth, and adds an iterative multi-cycle MUL/DIV unit (MDU) scoreboard. It sits beside the decode stage. It produces a stall, an issue strobe and per-operand forward selects, and it owns the in-flight write tracking for the whole back end.

Parameters:
AW, 5, register address width (2^AW registers; register 0 is hard-wired zero)
NSRC, 2, number of source operands checked per decoded instruction
DEPTH, 3, tracked stages after decode (1=EXE, 2=MEM, 3=WB)
LOAD_AVAIL, 2, first stage index at which load data is forwardable (1..DEPTH)
MDU_LAT, 4, MDU latency in cycles (>=1)
(localparam FW = clog2(DEPTH+2), forward-select width)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a valid instruction
id_src_addr  in  NSRC*AW  source register addresses; operand i is at [i*AW +: AW]
id_src_used  in  NSRC  operand i is actually read
id_dst_addr  in  AW  destination register
id_wreg  in  1  instruction writes id_dst_addr
id_load  in  1  instruction is a load
id_mdu  in  1  instruction goes to the MDU (its write is tracked by the MDU scoreboard only)
flush  in  1  cancel the decode-slot instruction (taken branch/jump)
stall  out  1  hold PC/IF/ID, inject bubble
issue  out  1  id_valid & ~stall & ~flush
fwd_sel  out  NSRC*FW  per operand: 0=regfile, k=stage k result (1..DEPTH), DEPTH+1=MDU result
mdu_busy  out  1  MDU operation in flight
mdu_done  out  1  one-cycle pulse; MDU result valid and written back this cycle
mdu_dst  out  AW  destination of the in-flight MDU operation
wb_dst  out  AW  destination in stage DEPTH
wb_wreg  out  1  stage DEPTH valid & wreg

Behaviour:
- State: stage[1..DEPTH] each {valid, dst, wreg, load}; mdu_busy, mdu_cnt, mdu_dst.
- Reset (rst=1 at an edge): all stage valid=0, mdu_busy=0, mdu_cnt=0, mdu_dst=0. After reset, all outputs are 0. Reset mid-MDU aborts the operation, and no mdu_done is produced.
- Every edge, stage[k+1]<=stage[k] unconditionally. There is no back-pressure downstream.
- stage[1]<=decode tags if issue & ~id_mdu; otherwise a bubble (valid=0).
- Match on operand i: id_src_used[i] & src!=0 & stage[k].valid & stage[k].wreg & stage[k].dst==src.
- Only the youngest match (smallest k) is considered.
  - If that match is a load with k<LOAD_AVAIL, the operand is a load-use hazard and raises stall.
  - Otherwise fwd_sel=k.
  - With no match, fwd_sel=0.
- MDU forwarding: if mdu_done & mdu_dst==src & src!=0, fwd_sel=DEPTH+1. This overrides any stage match.
- Stall conditions (OR, all gated by id_valid):
  - a load-use hazard on any operand;
  - a source equal to mdu_dst (src!=0) while mdu_busy & ~mdu_done;
  - id_mdu while mdu_busy & ~mdu_done;
  - WAW: id_wreg & id_dst_addr==mdu_dst & id_dst_addr!=0 while mdu_busy & ~mdu_done.
- fwd_sel is don't-care while stall=1. It must still be stable combinational, with no latches.
- flush has priority over stall for issue. flush does not alter stages in flight or the MDU.
- MDU timing:
  - On issue & id_mdu at edge t: mdu_busy<=1, mdu_cnt<=MDU_LAT, mdu_dst<=id_dst_addr.
  - While busy, mdu_cnt decrements each edge.
  - mdu_done = mdu_busy & (mdu_cnt==1), so it is high in the MDU_LAT-th cycle after issue.
  - At the edge ending the done cycle, mdu_busy<=0, unless a new MDU op issues that same cycle. In that case busy stays 1 and cnt/dst reload.
- MDU_LAT=1: done is high in the cycle right after issue.
- id_mdu with id_wreg=0 or dst=0 still occupies the MDU, but it never matches any source.

Test Plan:
(defaults; cycle numbers are relative to the first issue)
1. add r3 issued c0; in c1/c2/c3/c4 the decode reads r3 on operand 0 -> stall=0, fwd_sel[0]=1/2/3/0.
2. lw r4 issued c0; in c1 the decode reads r4 on operand 1 -> c1 stall=1 and stage1 bubble; c2 stall=0, fwd_sel[1]=2; c3 fwd_sel[1]=3.
3. lw r0 c0, then r0 read in c1 -> stall=0, fwd_sel=0. Also lw r5 c0, add r5 c1, r5 read in c2 -> fwd_sel=1 (youngest wins), no stall.
4. mul r7 issued c0 -> mdu_busy c1..c4, mdu_done=1 only in c4. A reader of r7 at c1 stalls c1..c3; c4 stall=0, fwd_sel=4, issue=1.
   A second MDU op presented at c2 stalls c2..c3 and issues c4; mdu_busy stays 1 continuously, and the next done is at c8.
5. mul r7 c0, then addi r7 presented c1 -> WAW stall c1..c3, issue c4. flush=1 with id_valid=1 and a hazard present -> issue=0, stage1 bubble next cycle.
6. mul r9 c0, rst=1 during c2 -> c3: mdu_busy=0, all stage valid=0, fwd_sel=0, and no mdu_done in any later cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: tracks in-flight destination tags across DEPTH stages
// plus one iterative MDU operation, and derives stall, issue and forward selects.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int MDU_LAT    = 4,
    localparam int FW        = $clog2(DEPTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_dst_addr,
    input  logic                 id_wreg,
    input  logic                 id_load,
    input  logic                 id_mdu,
    input  logic                 flush,
    output logic                 stall,
    output logic                 issue,
    output logic [NSRC*FW-1:0]   fwd_sel,
    output logic                 mdu_busy,
    output logic                 mdu_done,
    output logic [AW-1:0]        mdu_dst,
    output logic [AW-1:0]        wb_dst,
    output logic                 wb_wreg
);
    localparam int CW = $clog2(MDU_LAT + 1);

    logic          st_vld  [1:DEPTH];
    logic [AW-1:0] st_dst  [1:DEPTH];
    logic          st_wreg [1:DEPTH];
    logic          st_load [1:DEPTH];

    logic [CW-1:0] mdu_cnt;
    logic          mdu_wreg;
    logic          mdu_pend;
    logic          pipe_issue;
    logic          load_use;
    logic          mdu_raw;
    logic          waw;

    logic [AW-1:0] src;
    logic [FW-1:0] sel;
    logic          lu;
    logic          mdu_hit;

    assign mdu_done   = mdu_busy & (mdu_cnt == CW'(1));
    assign mdu_pend   = mdu_busy & ~mdu_done;
    assign pipe_issue = issue & ~id_mdu;

    // Tag pipeline: unconditional shift; bubbles carry all-zero tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                st_vld[k]  <= 1'b0;
                st_dst[k]  <= '0;
                st_wreg[k] <= 1'b0;
                st_load[k] <= 1'b0;
            end
        end else begin
            st_vld[1]  <= pipe_issue;
            st_dst[1]  <= pipe_issue ? id_dst_addr : '0;
            st_wreg[1] <= pipe_issue & id_wreg;
            st_load[1] <= pipe_issue & id_load;
            for (int k = 2; k <= DEPTH; k++) begin
                st_vld[k]  <= st_vld[k-1];
                st_dst[k]  <= st_dst[k-1];
                st_wreg[k] <= st_wreg[k-1];
                st_load[k] <= st_load[k-1];
            end
        end
    end

    // MDU scoreboard; a new op may reload in the done cycle of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_busy <= 1'b0;
            mdu_cnt  <= '0;
            mdu_dst  <= '0;
            mdu_wreg <= 1'b0;
        end else if (issue & id_mdu) begin
            mdu_busy <= 1'b1;
            mdu_cnt  <= CW'(MDU_LAT);
            mdu_dst  <= id_dst_addr;
            mdu_wreg <= id_wreg & (id_dst_addr != '0);
        end else if (mdu_busy) begin
            if (mdu_done) begin
                mdu_busy <= 1'b0;
                mdu_cnt  <= '0;
            end else begin
                mdu_cnt <= mdu_cnt - CW'(1);
            end
        end
    end

    // Oldest-to-youngest scan so the youngest match is the one left standing.
    always_comb begin
        load_use = 1'b0;
        mdu_raw  = 1'b0;
        fwd_sel  = '0;
        src      = '0;
        sel      = '0;
        lu       = 1'b0;
        mdu_hit  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src = id_src_addr[i*AW +: AW];
            sel = '0;
            lu  = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_src_used[i] && (src != '0) && st_vld[k] && st_wreg[k] && (st_dst[k] == src)) begin
                    sel = FW'(k);
                    lu  = st_load[k] && (k < LOAD_AVAIL);
                end
            end
            mdu_hit = id_src_used[i] && (src != '0) && mdu_wreg && (src == mdu_dst);
            if (mdu_hit && mdu_done) begin
                sel = FW'(DEPTH + 1);
                lu  = 1'b0;
            end
            if (mdu_hit && mdu_pend)
                mdu_raw = 1'b1;
            load_use = load_use | lu;
            fwd_sel[i*FW +: FW] = sel;
        end
    end

    assign waw   = id_wreg & (id_dst_addr != '0) & mdu_wreg & (id_dst_addr == mdu_dst) & mdu_pend;
    assign stall = id_valid & (load_use | mdu_raw | (id_mdu & mdu_pend) | waw);
    assign issue = id_valid & ~stall & ~flush;

    assign wb_dst  = st_dst[DEPTH];
    assign wb_wreg = st_vld[DEPTH] & st_wreg[DEPTH];

endmodule
